// File: rtl/serial_pair_pkg.sv
// Shared types and sizing helpers for the serial A/B pair transmitter.
package serial_pair_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_e;

   localparam int FS_W = 8;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_pair_tx_shifter.sv
// Two-lane parallel-in/serial-out register, LSB first.
module pair_shifter
   import serial_pair_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] a_word_i,
   input  logic [WIDTH-1:0] b_word_i,
   output logic             a_o,
   output logic             b_o
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   // Load wins so a back-to-back frame can start on the last bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q <= '0;
         b_q <= '0;
      end else if (load_i) begin
         a_q <= a_word_i;
         b_q <= b_word_i;
      end else if (shift_i) begin
         a_q <= a_q >> 1;
         b_q <= b_q >> 1;
      end
   end

   assign a_o = a_q[0];
   assign b_o = b_q[0];

endmodule

// File: rtl/serial_pair_tx.sv
// Word-pair to serial A/B transmitter with frame markers,
// optional inter-frame gap and a wrapping frame counter.
module serial_pair_tx
   import serial_pair_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_word,
   input  logic [WIDTH-1:0] b_word,
   output logic             A,
   output logic             B,
   output logic             bit_valid,
   output logic             first,
   output logic             last,
   output logic [FS_W-1:0]  frames_sent
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam int GAP_W = cnt_w(GAP);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [GAP_W-1:0]  gap_q;
   logic [FS_W-1:0]   frames_q;

   logic last_bit;
   logic gap_end;
   logic xfer;
   logic sh_a;
   logic sh_b;

   assign last_bit = (state_q == S_SHIFT) &&
                     (cnt_q == CNT_W'(WIDTH - 1));
   assign gap_end  = (state_q == S_GAP) &&
                     (gap_q == GAP_W'(GAP - 1));

   // Ready is a pure function of registered state.
   assign in_ready = (state_q == S_IDLE) ||
                     (last_bit && (GAP == 0)) ||
                     gap_end;
   assign xfer     = in_valid && in_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         gap_q    <= '0;
         frames_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (xfer) begin
                  state_q <= S_SHIFT;
                  cnt_q   <= '0;
               end
            end
            S_SHIFT: begin
               if (last_bit) begin
                  frames_q <= frames_q + 1'b1;
                  cnt_q    <= '0;
                  gap_q    <= '0;
                  if (GAP > 0)
                     state_q <= S_GAP;
                  else
                     state_q <= xfer ? S_SHIFT : S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_GAP: begin
               if (gap_end) begin
                  gap_q   <= '0;
                  state_q <= xfer ? S_SHIFT : S_IDLE;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   pair_shifter #(.WIDTH(WIDTH)) u_shift (
      .clk      (clk),
      .reset    (reset),
      .load_i   (xfer),
      .shift_i  (bit_valid),
      .a_word_i (a_word),
      .b_word_i (b_word),
      .a_o      (sh_a),
      .b_o      (sh_b)
   );

   assign bit_valid   = (state_q == S_SHIFT);
   assign A           = bit_valid && sh_a;
   assign B           = bit_valid && sh_b;
   assign first       = bit_valid && (cnt_q == '0);
   assign last        = last_bit;
   assign frames_sent = frames_q;

endmodule

// File: tb/tb_serial_pair_tx.sv
// Randomised bench: three transmitter configurations checked
// against a queue-of-cycles reference model.
module tb_serial_pair_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       iv  [3];
   logic       rdy [3];
   logic [7:0] aw  [3];
   logic [7:0] bw  [3];
   logic       A_s [3];
   logic       B_s [3];
   logic       bv  [3];
   logic       fi  [3];
   logic       la  [3];
   logic [7:0] fs  [3];

   int checks = 0;
   int fails  = 0;

   // Per-cycle expected output: {valid, a, b, first, last}.
   logic [4:0] mq [3][$];
   logic [7:0] xf [3];

   always #5 clk = ~clk;

   serial_pair_tx #(.WIDTH(8), .GAP(0)) u0 (
      .clk(clk), .reset(reset),
      .in_valid(iv[0]), .in_ready(rdy[0]),
      .a_word(aw[0]), .b_word(bw[0]),
      .A(A_s[0]), .B(B_s[0]), .bit_valid(bv[0]),
      .first(fi[0]), .last(la[0]), .frames_sent(fs[0])
   );

   serial_pair_tx #(.WIDTH(8), .GAP(2)) u1 (
      .clk(clk), .reset(reset),
      .in_valid(iv[1]), .in_ready(rdy[1]),
      .a_word(aw[1]), .b_word(bw[1]),
      .A(A_s[1]), .B(B_s[1]), .bit_valid(bv[1]),
      .first(fi[1]), .last(la[1]), .frames_sent(fs[1])
   );

   serial_pair_tx #(.WIDTH(1), .GAP(0)) u2 (
      .clk(clk), .reset(reset),
      .in_valid(iv[2]), .in_ready(rdy[2]),
      .a_word(aw[2][0:0]), .b_word(bw[2][0:0]),
      .A(A_s[2]), .B(B_s[2]), .bit_valid(bv[2]),
      .first(fi[2]), .last(la[2]), .frames_sent(fs[2])
   );

   function automatic int wd(input int i);
      return (i == 2) ? 1 : 8;
   endfunction

   function automatic int gp(input int i);
      return (i == 1) ? 2 : 0;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [4:0] cur;
      for (int i = 0; i < 3; i++) begin
         if (!reset) begin
            mq[i].delete();
            xf[i] = '0;
         end
         cur = (mq[i].size() > 0) ? mq[i].pop_front() : 5'b0;
         chk($sformatf("bv%0d", i), bv[i], cur[4]);
         chk($sformatf("A%0d", i), A_s[i], cur[3]);
         chk($sformatf("B%0d", i), B_s[i], cur[2]);
         chk($sformatf("first%0d", i), fi[i], cur[1]);
         chk($sformatf("last%0d", i), la[i], cur[0]);
         chk($sformatf("rdy%0d", i), rdy[i],
             mq[i].size() == 0);
         chk($sformatf("frames%0d", i), fs[i], xf[i]);
         if (reset) begin
            if (cur[0])
               xf[i] = xf[i] + 8'd1;
            if (iv[i] && mq[i].size() == 0) begin
               for (int b = 0; b < wd(i); b++)
                  mq[i].push_back({1'b1, aw[i][b], bw[i][b],
                                   b == 0, b == wd(i) - 1});
               for (int g = 0; g < gp(i); g++)
                  mq[i].push_back(5'b0);
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0;
         aw[i] = '0;
         bw[i] = '0;
      end
      repeat (2) tick();
      reset = 1'b1;
      tick();

      // Directed A5/3C frame, then ignored mid-frame pulses.
      aw[0] = 8'hA5;
      bw[0] = 8'h3C;
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      aw[0] = 8'hFF;
      bw[0] = 8'hFF;
      repeat (3) tick();
      iv[0] = 1'b1;
      repeat (2) tick();
      iv[0] = 1'b0;
      repeat (8) tick();
      chk("single_frame_count", fs[0], 8'd1);

      // Continuous valid: back-to-back and gapped frames.
      for (int c = 0; c < 60; c++) begin
         for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b1;
            aw[i] = 8'($urandom);
            bw[i] = 8'($urandom);
         end
         tick();
      end

      // Random valid with word churn while busy.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++) begin
            iv[i] = 1'($urandom);
            aw[i] = 8'($urandom);
            bw[i] = 8'($urandom);
         end
         tick();
      end

      for (int i = 0; i < 3; i++)
         iv[i] = 1'b0;
      repeat (12) tick();

      // Abort a frame after bit 3 with an async reset.
      aw[0] = 8'($urandom);
      bw[0] = 8'($urandom);
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      repeat (3) tick();
      #2;
      reset = 1'b0;
      #1;
      chk("rst_bv", bv[0], 1'b0);
      chk("rst_A", A_s[0], 1'b0);
      chk("rst_B", B_s[0], 1'b0);
      chk("rst_first", fi[0], 1'b0);
      chk("rst_last", la[0], 1'b0);
      chk("rst_rdy", rdy[0], 1'b1);
      chk("rst_frames", fs[0], 8'd0);
      @(negedge clk);
      tick();
      reset = 1'b1;
      aw[0] = 8'($urandom);
      bw[0] = 8'($urandom);
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      repeat (10) tick();
      chk("post_rst_frames", fs[0], 8'd1);

      // WIDTH=1: 256 frames wrap the counter.
      for (int c = 0; c < 256; c++) begin
         iv[2] = 1'b1;
         aw[2] = 8'($urandom);
         bw[2] = 8'($urandom);
         tick();
      end
      iv[2] = 1'b0;
      repeat (3) tick();
      chk("wrap_frames", fs[2], 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, fails);
      $finish;
   end

endmodule
